// File: rtl/rf_writeback_ctrl.sv
// Register-file write-back initiator: merges memory and ALU results through an
// in-order FIFO and drives one register-file write per cycle.
module rf_writeback_ctrl #(
  parameter  int N     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid_i,
  output logic          mem_ready_o,
  input  logic [4:0]    mem_rd_i,
  input  logic [N-1:0]  mem_data_i,
  input  logic          alu_valid_i,
  output logic          alu_ready_o,
  input  logic [4:0]    alu_rd_i,
  input  logic [N-1:0]  alu_data_i,
  output logic          Reg_Write_o,
  output logic [4:0]    Write_Register_o,
  output logic [N-1:0]  Write_Data_o,
  output logic [31:0]   busy_mask_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [4:0]       rd_q   [DEPTH];
  logic [N-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    rptr_q;
  logic [AW-1:0]    wptr_q;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    alu_idx;
  logic             push_mem;
  logic             push_alu;
  logic             pop;

  // Ready is judged on the registered count only; a pop in the same cycle frees nothing.
  assign mem_ready_o = (count_q < CW'(DEPTH));
  assign alu_ready_o = (count_q < CW'(DEPTH - 1)) ||
                       ((count_q == CW'(DEPTH - 1)) && !mem_valid_i);

  // rd 0 handshakes complete but are dropped on the floor.
  assign push_mem = mem_valid_i && mem_ready_o && (mem_rd_i != 5'd0);
  assign push_alu = alu_valid_i && alu_ready_o && (alu_rd_i != 5'd0);
  assign pop      = (count_q != '0);
  assign alu_idx  = wptr_q + AW'(push_mem);

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      vld_q            <= '0;
      rptr_q           <= '0;
      wptr_q           <= '0;
      count_q          <= '0;
      Reg_Write_o      <= 1'b0;
      Write_Register_o <= '0;
      Write_Data_o     <= '0;
    end else begin
      if (pop) begin
        vld_q[rptr_q]    <= 1'b0;
        Reg_Write_o      <= 1'b1;
        Write_Register_o <= rd_q[rptr_q];
        Write_Data_o     <= data_q[rptr_q];
        rptr_q           <= rptr_q + AW'(1);
      end else begin
        Reg_Write_o <= 1'b0;
      end
      // Memory always lands ahead of a same-cycle ALU result.
      if (push_mem) begin
        rd_q[wptr_q]   <= mem_rd_i;
        data_q[wptr_q] <= mem_data_i;
        vld_q[wptr_q]  <= 1'b1;
      end
      if (push_alu) begin
        rd_q[alu_idx]   <= alu_rd_i;
        data_q[alu_idx] <= alu_data_i;
        vld_q[alu_idx]  <= 1'b1;
      end
      wptr_q  <= wptr_q + AW'(push_mem) + AW'(push_alu);
      count_q <= count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    end
  end

  always_comb begin
    busy_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) busy_mask_o[rd_q[i]] = 1'b1;
    end
    if (Reg_Write_o) busy_mask_o[Write_Register_o] = 1'b1;
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_rf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid_i, alu_valid_i;
  logic        mem_ready_o, alu_ready_o;
  logic [4:0]  mem_rd_i, alu_rd_i;
  logic [31:0] mem_data_i, alu_data_i;
  logic        Reg_Write_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o;
  logic [31:0] busy_mask_o;
  logic [2:0]  count_o;
  logic        full_o, empty_o;

  rf_writeback_ctrl #(.N(32), .DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_valid_i      (mem_valid_i),
    .mem_ready_o      (mem_ready_o),
    .mem_rd_i         (mem_rd_i),
    .mem_data_i       (mem_data_i),
    .alu_valid_i      (alu_valid_i),
    .alu_ready_o      (alu_ready_o),
    .alu_rd_i         (alu_rd_i),
    .alu_data_i       (alu_data_i),
    .Reg_Write_o      (Reg_Write_o),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o),
    .busy_mask_o      (busy_mask_o),
    .count_o          (count_o),
    .full_o           (full_o),
    .empty_o          (empty_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: pending results as a queue plus the visible write stage.
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] rf_m [32];
  logic [31:0] rf_d [32];

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        emr;
    logic        ear;
    int          ecnt;
    logic        ewe;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic [31:0] ebusy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (q[i]) b[q[i].rd] = 1'b1;
    if (m_we) b[m_rd] = 1'b1;
    return b;
  endfunction

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    mem_valid_i = mv; mem_rd_i = mr; mem_data_i = md;
    alu_valid_i = av; alu_rd_i = ar; alu_data_i = ad;
  endtask

  task automatic step(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad);
    int   free;
    logic exp_mr, exp_ar;
    ent_t e;
    drive(mv, mr, md, av, ar, ad);
    @(negedge clk);
    free   = 4 - q.size();
    exp_mr = (free > 0);
    exp_ar = ((free - (mv ? 1 : 0)) > 0);
    chk("mem_ready", 32'(mem_ready_o), 32'(exp_mr));
    chk("alu_ready", 32'(alu_ready_o), 32'(exp_ar));
    chk("count", 32'(count_o), 32'(q.size()));
    chk("full", 32'(full_o), 32'(q.size() == 4));
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("reg_write", 32'(Reg_Write_o), 32'(m_we));
    chk("write_reg", 32'(Write_Register_o), 32'(m_rd));
    chk("write_data", Write_Data_o, m_data);
    chk("busy_mask", busy_mask_o, model_busy());
    if (Reg_Write_o) begin
      chk("wr_rd_nonzero", 32'(Write_Register_o != 5'd0), 32'd1);
      rf_d[Write_Register_o] = Write_Data_o;
    end
    @(posedge clk);
    if (m_we) rf_m[m_rd] = m_data;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (mv && exp_mr && mr != 5'd0) q.push_back('{rd: mr, data: md});
    if (av && exp_ar && ar != 5'd0) q.push_back('{rd: ar, data: ad});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic model_clear();
    q.delete();
    m_we = 1'b0; m_rd = '0; m_data = '0;
  endtask

  // Called just after a rising edge; releases reset on the following falling edge.
  task automatic do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf_m[r] = '0;
      rf_d[r] = '0;
    end
    model_clear();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b0;

    vecs[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hA5,        1'b1, 1'b1, 0, 1'b0, 5'd0, 32'h0,  32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1, 1'b0, 5'd0, 32'h0,  32'h20};
    vecs[2] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,        1'b1, 1'b1, 0, 1'b1, 5'd5, 32'hA5, 32'h20};
    vecs[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 2, 1'b0, 5'd5, 32'hA5, 32'h8};
    vecs[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1, 1'b1, 5'd3, 32'h11, 32'h8};
    vecs[5] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 0, 1'b1, 5'd3, 32'h22, 32'h8};
    vecs[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 0, 1'b0, 5'd3, 32'h22, 32'h0};

    @(posedge clk);
    #1;
    do_reset();

    // Directed table: single ALU write, same-rd pair in order, rd 0 drop.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].av, vecs[i].ard, vecs[i].ad);
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_ready", i), 32'(mem_ready_o), 32'(vecs[i].emr));
      chk($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready_o), 32'(vecs[i].ear));
      chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(vecs[i].ecnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty_o), 32'(vecs[i].ecnt == 0));
      chk($sformatf("tbl%0d_reg_write", i), 32'(Reg_Write_o), 32'(vecs[i].ewe));
      chk($sformatf("tbl%0d_write_reg", i), 32'(Write_Register_o), 32'(vecs[i].ewr));
      chk($sformatf("tbl%0d_write_data", i), Write_Data_o, vecs[i].ewd);
      chk($sformatf("tbl%0d_busy", i), busy_mask_o, vecs[i].ebusy);
      @(posedge clk);
      #1;
    end

    // count == DEPTH-1 with both producers valid: memory wins, ALU waits one cycle.
    do_reset();
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    chk("cnt_at_3", 32'(count_o), 32'd3);
    drive(1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6);
    #1;
    chk("mem_ready_at_3", 32'(mem_ready_o), 32'd1);
    chk("alu_stall_at_3", 32'(alu_ready_o), 32'd0);
    step(1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6);
    #1;
    chk("alu_ready_after_pop", 32'(alu_ready_o), 32'd1);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6);
    idle(6);

    // Reset asserted mid-operation with three entries queued and a strobe live.
    step(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80);
    step(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0);
    chk("pre_rst_count", 32'(count_o), 32'd3);
    chk("pre_rst_we", 32'(Reg_Write_o), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_async_we", 32'(Reg_Write_o), 32'd0);
    chk("rst_async_wr", 32'(Write_Register_o), 32'd0);
    chk("rst_async_wd", Write_Data_o, 32'd0);
    chk("rst_async_busy", busy_mask_o, 32'd0);
    chk("rst_async_count", 32'(count_o), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(4);

    // Both producers held valid: one strobe per cycle, nothing lost or duplicated.
    for (int i = 0; i < 24; i++)
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    idle(6);

    // Random traffic with a narrow rd range to force same-register collisions.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
    idle(8);

    for (int r = 0; r < 32; r++)
      chk($sformatf("rf_final_r%0d", r), rf_d[r], rf_m[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
